// File: rtl/sdram_arbiter.sv
`default_nettype none
// sdram_arbiter - two-port round-robin request arbiter for the SDRAM control unit (rev 1.0)
module sdram_arbiter #(
   parameter int ADDR_WIDTH  = 24,
   parameter int DATA_WIDTH  = 32,
   parameter int SELECT_HOLD = 16
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  wr0,
   input  logic                  wr1,
   input  logic                  brst0,
   input  logic                  brst1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  done0,
   output logic                  done1,
   input  logic                  idle,
   input  logic [2:0]            opcode,
   output logic                  select,
   output logic                  r_enable,
   output logic                  w_enable,
   output logic                  burst,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  owner,
   output logic                  busy
);

   localparam int HOLD_W = (SELECT_HOLD > 0) ? $clog2(SELECT_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SELECT_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   typedef enum logic [1:0] {
      ARB       = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t                state;
   logic                  wr_q;
   logic                  brst_q;
   logic                  last_grant;
   logic [HOLD_W-1:0]     hold_cnt;
   logic                  winner;
   logic                  win_wr;
   logic                  win_brst;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;

   // On a tie the port that did not win last time gets the controller.
   always_comb begin
      winner    = (req0 && req1) ? !last_grant : req1;
      win_wr    = winner ? wr1    : wr0;
      win_brst  = winner ? brst1  : brst0;
      win_addr  = winner ? addr1  : addr0;
      win_wdata = winner ? wdata1 : wdata0;
   end

   assign busy   = (state != ARB);
   assign select = busy | req0 | req1 | (hold_cnt != '0);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= ARB;
         wr_q       <= 1'b0;
         brst_q     <= 1'b0;
         last_grant <= 1'b1;
         hold_cnt   <= '0;
         owner      <= 1'b0;
         addr       <= '0;
         wdata      <= '0;
         r_enable   <= 1'b0;
         w_enable   <= 1'b0;
         burst      <= 1'b0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            ARB: begin
               if (req0 || req1) begin
                  state      <= ISSUE;
                  owner      <= winner;
                  last_grant <= winner;
                  wr_q       <= win_wr;
                  brst_q     <= win_brst;
                  addr       <= win_addr;
                  wdata      <= win_wdata;
                  r_enable   <= !win_wr;
                  w_enable   <= win_wr;
                  burst      <= win_brst;
                  gnt0       <= !winner;
                  gnt1       <= winner;
               end else if (hold_cnt != '0) begin
                  hold_cnt <= hold_cnt - HOLD_ONE;
               end
            end
            // Command stays presented until the controller echoes the matching opcode.
            ISSUE: begin
               if (opcode == {1'b1, wr_q, brst_q}) begin
                  state    <= WAIT_BUSY;
                  r_enable <= 1'b0;
                  w_enable <= 1'b0;
                  burst    <= 1'b0;
               end
            end
            WAIT_BUSY: begin
               if (!idle) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (idle) begin
                  state    <= ARB;
                  done0    <= !owner;
                  done1    <= owner;
                  hold_cnt <= HOLD_LOAD;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// tb_sdram_arbiter - randomized two-master traffic and a behavioural controller against a transaction-level model.
module tb_sdram_arbiter;

   localparam int AW   = 24;
   localparam int DW   = 32;
   localparam int HOLD = 16;

   localparam int P_IDLE  = 0;
   localparam int P_STALL = 1;
   localparam int P_ACC   = 2;
   localparam int P_BUSY  = 3;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic [1:0]    req_v = 2'b00;
   logic [1:0]    wr_v = 2'b00;
   logic [1:0]    brst_v = 2'b00;
   logic [AW-1:0] addr_v [2];
   logic [DW-1:0] wdata_v [2];
   logic          idle = 1'b1;
   logic [2:0]    opcode = 3'd0;

   logic          gnt0, gnt1, done0, done1;
   logic          select, r_enable, w_enable, burst, owner, busy;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;

   sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_HOLD(HOLD)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .req0     (req_v[0]),
      .req1     (req_v[1]),
      .wr0      (wr_v[0]),
      .wr1      (wr_v[1]),
      .brst0    (brst_v[0]),
      .brst1    (brst_v[1]),
      .addr0    (addr_v[0]),
      .addr1    (addr_v[1]),
      .wdata0   (wdata_v[0]),
      .wdata1   (wdata_v[1]),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .done0    (done0),
      .done1    (done1),
      .idle     (idle),
      .opcode   (opcode),
      .select   (select),
      .r_enable (r_enable),
      .w_enable (w_enable),
      .burst    (burst),
      .addr     (addr),
      .wdata    (wdata),
      .owner    (owner),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Transaction-level model state
   bit            want_gnt, gnt_port, last_win;
   bit            outstanding, cmd_live, done_due, any_done;
   bit            hold_busy, allow_new;
   bit            cur_port, cur_wr, cur_brst;
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_wdata;
   bit   [1:0]    waiting;
   int            since_done, stall, extra, ctl_phase;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      want_gnt = 0; gnt_port = 0; last_win = 1;
      outstanding = 0; cmd_live = 0; done_due = 0; any_done = 0;
      hold_busy = 0; waiting = 2'b00; since_done = 0;
      stall = 0; extra = 0; ctl_phase = P_IDLE;
   endtask

   // Decide who the arbiter must grant next cycle from the requests now on the wires.
   task automatic arm_grant();
      if (!outstanding && !want_gnt && (req_v != 2'b00)) begin
         gnt_port  = (req_v == 2'b11) ? !last_win : req_v[1];
         last_win  = gnt_port;
         want_gnt  = 1;
         cur_port  = gnt_port;
         cur_wr    = wr_v[gnt_port];
         cur_brst  = brst_v[gnt_port];
         cur_addr  = addr_v[gnt_port];
         cur_wdata = wdata_v[gnt_port];
      end
   endtask

   task automatic step();
      logic [2:0] exp_op;
      logic [2:0] op;
      @(negedge clk);
      if (want_gnt) begin
         outstanding = 1;
         cmd_live    = 1;
         ctl_phase   = P_STALL;
         stall       = $urandom_range(0, 3);
      end
      if (done_due) begin
         outstanding = 0;
         any_done    = 1;
         since_done  = 0;
      end
      exp_op = {1'b1, cur_wr, cur_brst};

      check_val("gnt0", gnt0, want_gnt && !gnt_port);
      check_val("gnt1", gnt1, want_gnt && gnt_port);
      check_val("done0", done0, done_due && !cur_port);
      check_val("done1", done1, done_due && cur_port);
      check_val("busy", busy, outstanding);
      check_val("r_enable", r_enable, cmd_live && !cur_wr);
      check_val("w_enable", w_enable, cmd_live && cur_wr);
      check_val("burst", burst, cmd_live && cur_brst);
      check_val("select", select,
                outstanding | req_v[0] | req_v[1] | (any_done && since_done < HOLD));
      if (outstanding) begin
         check_val("owner", owner, cur_port);
         check_val("addr", addr, cur_addr);
         check_val("wdata", wdata, cur_wdata);
      end

      if (want_gnt) begin
         req_v[gnt_port]   = 1'b0;
         waiting[gnt_port] = 1'b1;
      end
      if (done_due) waiting[cur_port] = 1'b0;
      want_gnt = 0;
      done_due = 0;

      case (ctl_phase)
         P_STALL: begin
            if (stall > 0) begin
               op = 3'($urandom_range(0, 7));
               if (op == exp_op) op = 3'd2;
               opcode = op;
               idle   = 1'b1;
               stall--;
            end else begin
               opcode    = exp_op;
               idle      = 1'b1;
               cmd_live  = 0;
               ctl_phase = P_ACC;
            end
         end
         P_ACC: begin
            idle      = 1'b0;
            extra     = $urandom_range(0, 2);
            ctl_phase = P_BUSY;
         end
         P_BUSY: begin
            if (hold_busy || extra > 0) begin
               idle = 1'b0;
               if (extra > 0) extra--;
            end else begin
               idle      = 1'b1;
               opcode    = 3'd0;
               done_due  = 1;
               ctl_phase = P_IDLE;
            end
         end
         default: begin
            idle   = 1'b1;
            opcode = 3'd0;
         end
      endcase

      for (int p = 0; p < 2; p++) begin
         if (allow_new && !req_v[p] && !waiting[p] && $urandom_range(0, 2) == 0) begin
            req_v[p]   = 1'b1;
            wr_v[p]    = 1'($urandom);
            brst_v[p]  = 1'($urandom);
            addr_v[p]  = AW'($urandom);
            wdata_v[p] = $urandom;
         end
      end
      arm_grant();
      if (any_done && since_done < 1000) since_done++;
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while ((outstanding || want_gnt || req_v != 2'b00) && n < limit) begin
         step();
         n++;
      end
      check_val("drain_timeout", {62'd0, outstanding, (req_v != 2'b00)}, 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_gnt"}, {gnt1, gnt0}, 2'b00);
      check_val({tag, "_done"}, {done1, done0}, 2'b00);
      check_val({tag, "_strobes"}, {r_enable, w_enable, burst}, 3'b000);
      check_val({tag, "_busy"}, busy, 1'b0);
      check_val({tag, "_select"}, select, 1'b0);
      check_val({tag, "_owner"}, owner, 1'b0);
      check_val({tag, "_addr"}, addr, '0);
      check_val({tag, "_wdata"}, wdata, '0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
      model_reset();
      allow_new = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      n_rst = 1'b1;

      // Contest from reset: port 0 single read, port 1 burst write
      req_v = 2'b11; wr_v = 2'b10; brst_v = 2'b10;
      addr_v[0] = 24'h001234; wdata_v[0] = 32'h0;
      addr_v[1] = 24'hABCDEF; wdata_v[1] = 32'hDEADBEEF;
      arm_grant();
      drain(200);

      for (int r = 0; r < 6; r++) begin
         allow_new = 1;
         repeat (200) step();
         allow_new = 0;
         repeat ($urandom_range(5, 30)) step();
      end
      drain(200);
      repeat (24) step();

      // Reset while the controller is still busy with port 1's command
      req_v[1] = 1'b1; wr_v[1] = 1'b1; brst_v[1] = 1'b0;
      addr_v[1] = 24'h0055AA; wdata_v[1] = 32'h12345678;
      hold_busy = 1;
      arm_grant();
      repeat (10) step();
      #2 n_rst = 1'b0;
      #1 check_reset_outputs("midreset");
      model_reset();
      req_v = 2'b00; idle = 1'b1; opcode = 3'd0;
      @(negedge clk);
      n_rst = 1'b1;
      req_v = 2'b11; wr_v = 2'b00; brst_v = 2'b01;
      addr_v[0] = 24'h000100; addr_v[1] = 24'h000200;
      wdata_v[0] = 32'hCAFE0000; wdata_v[1] = 32'hCAFE0001;
      arm_grant();
      drain(200);
      repeat (20) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port request arbiter in front of the SDRAM main control unit. It accepts single/burst read and write requests from two masters (port 0, port 1), grants the controller round-robin, and drives the controller's select/r_enable/w_enable/burst strobes plus the muxed address and write data. It holds each command until the controller's opcode confirms acceptance, and returns a completion pulse to the owning port. It keeps select asserted long enough to stop the controller from dropping into self-refresh between back-to-back traffic.

## Interface
- ADDR_WIDTH, 24, request address width
- DATA_WIDTH, 32, write data width
- SELECT_HOLD, 16, cycles select stays high after a completion with no pending request (0 = drop immediately)

- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  port request, level
- wr0 / wr1  in  1  1 = write, 0 = read
- brst0 / brst1  in  1  1 = burst, 0 = single
- addr0 / addr1  in  ADDR_WIDTH  request address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request latched, port may change inputs
- done0 / done1  out  1  one-cycle pulse: command complete
- idle  in  1  controller idle flag
- opcode  in  3  controller opcode (0 ready, 1 init, 2 self-ref, 3 auto-ref, 4 read, 5 read burst, 6 write, 7 write burst)
- select, r_enable, w_enable, burst  out  1  controller strobes
- addr  out  ADDR_WIDTH  registered address to controller
- wdata  out  DATA_WIDTH  registered write data to controller
- owner  out  1  port currently owning the controller (valid when busy)
- busy  out  1  high in every state except ARB

## Operation
- States: ARB, ISSUE, WAIT_BUSY, WAIT_DONE.
- ARB: if any req, choose winner; latch winner's wr, brst, addr, wdata into addr/wdata/command registers, set owner, last_grant = winner; -> ISSUE. No req: stay.
- Round-robin: only one req -> that port. Both -> port != last_grant. last_grant resets to 1 (port 0 wins first contest).
- ISSUE: r_enable = !wr_q, w_enable = wr_q, burst = brst_q. expected = {wr_q, brst_q} mapped to 4/5/6/7. When opcode == expected -> WAIT_BUSY. Any other opcode (0,1,2,3 or other op) -> hold strobes, stay (controller in init/refresh takes priority; command re-presented until accepted).
- WAIT_BUSY: strobes low; idle == 0 -> WAIT_DONE.
- WAIT_DONE: strobes low; idle == 1 -> ARB, done[owner] pulses next cycle, hold counter loads SELECT_HOLD.
- select = busy | req0 | req1 | (hold_cnt != 0). hold_cnt decrements in ARB while no req, saturates at 0; width clog2(SELECT_HOLD+1).
- r_enable/w_enable/burst are 0 outside ISSUE; never both enables high.
- req during ISSUE/WAIT_* is ignored; a req still high in ARB after done is a new request.

## Timing
- Reset values: state ARB, all strobes 0, gnt/done 0, addr/wdata 0, owner 0, busy 0, hold_cnt 0, last_grant 1.
- Reset mid-operation: immediate return to ARB, no done pulse, select drops.
- Strobes, gnt, done, busy are registered-state decodes (Moore); no combinational input->output path except select from req.
- Request sampled edge N -> ISSUE cycle N+1: gnt high, enable high. Controller ready -> opcode match cycle N+2 -> WAIT_BUSY at N+3 (strobes low).
- done asserts the cycle after WAIT_DONE samples idle=1; ARB may grant a new request that same cycle (gnt and done in adjacent cycles, possibly different ports).
- Minimum request-to-done latency with immediately-ready controller and one busy cycle: 5 cycles.

## Test plan
- Single read port 0, controller ready: req0=1 wr0=0 brst0=0 addr0=0x00_1234 -> gnt0 cycle 1, r_enable=1 burst=0 addr=0x001234; opcode 4 -> strobes low; idle 1->0->1 -> done0 one cycle, owner=0.
- Simultaneous req0 and req1 (port1 burst write, wdata1=0xDEADBEEF) from reset -> port 0 first, then port 1 with w_enable=1 burst=1 wdata=0xDEADBEEF; repeat both -> order alternates 0,1,0,1.
- Refresh collision: ISSUE with opcode=3 for 10 cycles then 0 then 6 -> w_enable held all 11 cycles, exactly one write accepted, one done.
- Select hold, SELECT_HOLD=16: one write completes, no further req -> select high exactly 16 cycles after done, then 0; new req at cycle 8 -> select never drops.
- Controller in self-refresh (opcode 2, idle 1): req1 read -> select rises same cycle, r_enable held until opcode 4.
- n_rst low during WAIT_DONE -> all outputs reset values, no done, next req1 wins with last_grant=1 behaviour (port 0 if both).
